// File: rtl/gcd_engine.sv
// gcd_engine: multi-cycle unsigned GCD unit.
//
// The algorithm is picked by a parameter: MODE=0 is subtractive Euclid and
// MODE=1 is binary (Stein) GCD. The engine does one algorithm step per clock.
// Operands come in on a valid/ready handshake. The result is held on a
// valid/ack handshake until the consumer acknowledges it.
//
// Optional feature: define GCD_CYCLE_COUNT_EN to add the `cycles` output. It
// reports how many CALC cycles the last operation took, and it saturates.
//
// Ports:
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   operands_valid in   A_in/B_in valid this cycle (sampled only in IDLE)
//   A_in, B_in     in   unsigned operands, WIDTH bits
//   ready          out  engine idle, will capture operands on operands_valid
//   gcd_valid      out  gcd_out holds a finished result
//   gcd_out        out  unsigned result, held until the next capture
//   ack            in   consumer has taken the result (sampled only in DONE)
//   cycles         out  CALC-cycle count, CNT_W bits (GCD_CYCLE_COUNT_EN only)
module gcd_engine #(
  parameter int WIDTH = 16,
  parameter int MODE  = 0,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             operands_valid,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             ready,
  output logic             gcd_valid,
  output logic [WIDTH-1:0] gcd_out,
`ifdef GCD_CYCLE_COUNT_EN
  output logic [CNT_W-1:0] cycles,
`endif
  input  logic             ack
);

  // k counts the common factors of two that Stein strips off. It must be able
  // to hold WIDTH, so it gets one bit more than log2(WIDTH).
  localparam int K_W = $clog2(WIDTH) + 1;

  localparam logic [WIDTH-1:0] ZERO   = {WIDTH{1'b0}};
  localparam logic [K_W-1:0]   K_ZERO = {K_W{1'b0}};
  localparam logic [K_W-1:0]   K_ONE  = {{(K_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [K_W-1:0]   k;

`ifdef GCD_CYCLE_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
`endif

  // Control FSM and datapath: capture, one algorithm step per CALC cycle,
  // result hold. All outputs are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      gcd_valid <= 1'b0;
      gcd_out   <= ZERO;
      a         <= ZERO;
      b         <= ZERO;
      k         <= K_ZERO;
`ifdef GCD_CYCLE_COUNT_EN
      cycles    <= CNT_ZERO;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (operands_valid) begin
            a      <= A_in;
            b      <= B_in;
            k      <= K_ZERO;
`ifdef GCD_CYCLE_COUNT_EN
            cycles <= CNT_ZERO;
`endif
            ready  <= 1'b0;
            state  <= CALC;
          end
        end

        CALC: begin
`ifdef GCD_CYCLE_COUNT_EN
          // The final (terminating) step is counted too.
          if (cycles != CNT_MAX) begin
            cycles <= cycles + CNT_ONE;
          end
`endif
          if (MODE == 0) begin
            // Euclid: keep A >= B by swapping, subtract until B reaches zero.
            if (a < b) begin
              a <= b;
              b <= a;
            end else if (b != ZERO) begin
              a <= a - b;
            end else begin
              gcd_out   <= a;
              gcd_valid <= 1'b1;
              state     <= DONE;
            end
          end else begin
            // Stein: strip shared twos into k, then strip single twos, then
            // subtract the smaller odd value from the larger. When one side
            // reaches zero the other side, scaled by 2^k, is the answer.
            if (a == ZERO) begin
              gcd_out   <= b << k;
              gcd_valid <= 1'b1;
              state     <= DONE;
            end else if (b == ZERO) begin
              gcd_out   <= a << k;
              gcd_valid <= 1'b1;
              state     <= DONE;
            end else if (!a[0] && !b[0]) begin
              a <= a >> 1;
              b <= b >> 1;
              k <= k + K_ONE;
            end else if (!a[0]) begin
              a <= a >> 1;
            end else if (!b[0]) begin
              b <= b >> 1;
            end else if (a >= b) begin
              a <= a - b;
            end else begin
              b <= b - a;
            end
          end
        end

        DONE: begin
          // gcd_out stays as it is. Only the handshake flags move.
          if (ack) begin
            gcd_valid <= 1'b0;
            ready     <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          ready     <= 1'b1;
          gcd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: scoreboard bench for gcd_engine.
//
// Three engines run side by side: WIDTH16/MODE0, WIDTH16/MODE1 and
// WIDTH32/MODE1. The driver applies directed vectors, each with a
// hand-computed result and CALC-cycle count, and pushes the expectation into
// a queue. A monitor pops an entry on every rising gcd_valid. It compares the
// result against the hand value and against a behavioural GCD model, and it
// compares the measured latency against the hand count.
`timescale 1ns/1ps
module tb_gcd_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_v [3];
  logic [31:0] a_v     [3];
  logic [31:0] b_v     [3];
  logic        ack_v   [3];
  logic        ready_v [3];
  logic        gv_v    [3];
  logic        gv_prev [3];
  logic [31:0] out_v   [3];
  logic [15:0] out0, out1;
  logic [31:0] out2;

  assign out_v[0] = {16'h0000, out0};
  assign out_v[1] = {16'h0000, out1};
  assign out_v[2] = out2;

`ifdef GCD_CYCLE_COUNT_EN
  logic [23:0] cnt0, cnt1, cnt2;
  logic [31:0] cnt_v [3];
  assign cnt_v[0] = {8'h00, cnt0};
  assign cnt_v[1] = {8'h00, cnt1};
  assign cnt_v[2] = {8'h00, cnt2};
`endif

  gcd_engine #(.WIDTH(16), .MODE(0)) u_e0 (
    .clk(clk), .reset_n(reset_n), .operands_valid(valid_v[0]),
    .A_in(a_v[0][15:0]), .B_in(b_v[0][15:0]), .ready(ready_v[0]),
    .gcd_valid(gv_v[0]), .gcd_out(out0),
`ifdef GCD_CYCLE_COUNT_EN
    .cycles(cnt0),
`endif
    .ack(ack_v[0]));

  gcd_engine #(.WIDTH(16), .MODE(1)) u_e1 (
    .clk(clk), .reset_n(reset_n), .operands_valid(valid_v[1]),
    .A_in(a_v[1][15:0]), .B_in(b_v[1][15:0]), .ready(ready_v[1]),
    .gcd_valid(gv_v[1]), .gcd_out(out1),
`ifdef GCD_CYCLE_COUNT_EN
    .cycles(cnt1),
`endif
    .ack(ack_v[1]));

  gcd_engine #(.WIDTH(32), .MODE(1)) u_e2 (
    .clk(clk), .reset_n(reset_n), .operands_valid(valid_v[2]),
    .A_in(a_v[2]), .B_in(b_v[2]), .ready(ready_v[2]),
    .gcd_valid(gv_v[2]), .gcd_out(out2),
`ifdef GCD_CYCLE_COUNT_EN
    .cycles(cnt2),
`endif
    .ack(ack_v[2]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          acc;
  } ent_t;

  ent_t sb[$];
  ent_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [31:0] gcd_model(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] p, q, t;
    p = x;
    q = y;
    while (q != 32'd0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: on each rising gcd_valid, pop the oldest expectation and compare.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (gv_v[d] === 1'b1 && gv_prev[d] !== 1'b1) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_result", 32'(d), 32'hFFFF_FFFF);
        end else begin
          mon_e = sb.pop_front();
          check("sb_engine_id", 32'(d), 32'(mon_e.id));
          check("gcd_out", out_v[d], mon_e.exp);
          check("gcd_model", out_v[d], gcd_model(mon_e.a, mon_e.b));
          if (mon_e.lat >= 0) begin
            check("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
`ifdef GCD_CYCLE_COUNT_EN
            check("cycles", cnt_v[d], 32'(mon_e.lat));
`endif
          end
        end
      end
      gv_prev[d] = gv_v[d];
    end
  end

  // Drive one operand pair into engine d and optionally push its expectation.
  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit push);
    ent_t e;
    bit   ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ready_v[d] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ready_timeout", 32'(ready_v[d]), 32'd1);
    valid_v[d] = 1'b1;
    a_v[d] = a;
    b_v[d] = b;
    @(posedge clk);
    #1;
    valid_v[d] = 1'b0;
    if (push) begin
      e.id = d; e.a = a; e.b = b; e.exp = exp; e.lat = lat; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  // Wait, with a bound, at negedges until engine d shows gcd_valid.
  task automatic wait_valid(input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (gv_v[d] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("gcd_valid_timeout", 32'(gv_v[d]), 32'd1);
  endtask

  // Pulse ack for one clock edge. The call is made at a negedge.
  task automatic do_ack(input int d);
    ack_v[d] = 1'b1;
    @(posedge clk);
    #1;
    ack_v[d] = 1'b0;
  endtask

  task automatic run(input int d, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat);
    issue(d, a, b, exp, lat, 1'b1);
    wait_valid(d);
    do_ack(d);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      valid_v[d] = 1'b0; a_v[d] = 32'd0; b_v[d] = 32'd0; ack_v[d] = 1'b0; gv_prev[d] = 1'b0;
    end
    #23;
    for (int d = 0; d < 3; d++) begin
      check("reset_ready", 32'(ready_v[d]), 32'd1);
      check("reset_gcd_valid", 32'(gv_v[d]), 32'd0);
      check("reset_gcd_out", out_v[d], 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // MODE0 32,16: hold the result for 5 cycles before ack.
    issue(0, 32'd32, 32'd16, 32'd16, 4, 1'b1);
    wait_valid(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_gcd_valid", 32'(gv_v[0]), 32'd1);
      check("hold_gcd_out", out_v[0], 32'd16);
    end
    do_ack(0);
    @(negedge clk);
    check("after_ack_gcd_valid", 32'(gv_v[0]), 32'd0);
    check("after_ack_ready", 32'(ready_v[0]), 32'd1);
    check("after_ack_gcd_out", out_v[0], 32'd16);

    run(1, 32'd32, 32'd16, 32'd16, 7);
    run(1, 32'd48, 32'd18, 32'd6,  8);
    run(0, 32'd48, 32'd18, 32'd6,  9);
    run(0, 32'd0,  32'd0,  32'd0,  1);
    run(1, 32'd0,  32'd0,  32'd0,  1);
    run(0, 32'd0,  32'd9,  32'd9,  2);
    run(1, 32'd0,  32'd9,  32'd9,  1);
    run(0, 32'd9,  32'd0,  32'd9,  1);
    run(1, 32'd9,  32'd0,  32'd9,  1);
    run(0, 32'd7,  32'd7,  32'd7,  3);
    run(1, 32'd7,  32'd7,  32'd7,  2);

    // Reset in the middle of a long MODE0 computation.
    issue(0, 32'd65535, 32'd1, 32'd1, -1, 1'b0);
    repeat (100) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_ready", 32'(ready_v[0]), 32'd1);
    check("midreset_gcd_valid", 32'(gv_v[0]), 32'd0);
    check("midreset_gcd_out", out_v[0], 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run(0, 32'd12, 32'd8, 32'd4, 6);
    run(1, 32'd12, 32'd8, 32'd4, 7);

    // operands_valid while busy is ignored.
    issue(0, 32'd48, 32'd18, 32'd6, 9, 1'b1);
    @(negedge clk);
    valid_v[0] = 1'b1; a_v[0] = 32'd5; b_v[0] = 32'd10;
    repeat (2) @(negedge clk);
    valid_v[0] = 1'b0;
    wait_valid(0);
    check("busy_ignored_gcd_out", out_v[0], 32'd6);
    do_ack(0);

    // ack held high everywhere: DONE lasts one cycle, then accept right away.
    ack_v[1] = 1'b1;
    issue(1, 32'd7, 32'd7, 32'd7, 2, 1'b1);
    wait_valid(1);
    @(negedge clk);
    check("ackhigh_gcd_valid", 32'(gv_v[1]), 32'd0);
    check("ackhigh_ready", 32'(ready_v[1]), 32'd1);
    ack_v[1] = 1'b0;
    run(1, 32'd9, 32'd0, 32'd9, 1);

    // 32-bit Stein engine.
    run(2, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'h0000_FFFF, -1);
    run(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    run(2, 32'h8000_0000, 32'h0000_0006, 32'h0000_0002, -1);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gcd_engine.md
Name: gcd_engine

Overview:
- Parametrised multi-cycle GCD unit; next generation of the fixed 16-bit subtractive GCD block.
- Generalised in operand width and algorithm: subtractive Euclid or binary (Stein) GCD, selected by parameter.
- Operands arrive on a valid/ready handshake; the result is held with a valid/ack handshake.
- Sits between an operand producer and a result consumer in the arithmetic datapath.

Parameters:
- WIDTH, 16, operand and result width in bits (>=2).
- MODE, 0, algorithm: 0 = subtractive Euclid, 1 = binary Stein.
- CNT_W, 24, width of the cycle counter (used only with GCD_CYCLE_COUNT_EN).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- operands_valid  input  1  A_in/B_in valid this cycle.
- A_in  input  WIDTH  operand A, unsigned.
- B_in  input  WIDTH  operand B, unsigned.
- ready  output  1  engine idle and able to accept operands.
- gcd_valid  output  1  gcd_out holds a finished result.
- gcd_out  output  WIDTH  result, unsigned.
- ack  input  1  consumer has taken the result.

Behaviour:
- Reset:
  - reset_n low asynchronously forces state IDLE.
  - ready=1, gcd_valid=0, gcd_out=0, internal A/B/k=0, cycles=0.
  - Applies mid-computation: the in-flight result is discarded.
- States: IDLE, CALC, DONE.
- IDLE:
  - ready=1.
  - On an edge with operands_valid=1, capture A_in->A, B_in->B, clear k and the cycle counter, then go to CALC.
  - ready drops the next cycle.
- CALC: ready=0; exactly one step per cycle, count incremented each CALC cycle.
  - MODE 0, in priority order:
    - A<B: swap A and B.
    - else B!=0: A<=A-B.
    - else: gcd_out<=A, go to DONE.
  - MODE 1, in priority order:
    - A==0: gcd_out<=B<<k, go to DONE.
    - B==0: gcd_out<=A<<k, go to DONE.
    - both even: A>>=1, B>>=1, k++.
    - A even: A>>=1.
    - B even: B>>=1.
    - A>=B: A<=A-B.
    - else: B<=B-A.
  - k is $clog2(WIDTH)+1 bits. The shifted result never exceeds WIDTH bits, so no overflow handling is needed.
- DONE:
  - gcd_valid=1 and gcd_out stable.
  - On an edge with ack=1, go to IDLE: gcd_valid=0, ready=1 the next cycle.
  - gcd_out keeps its value until the next capture.
- Latency (accept edge to gcd_valid rising): equals the number of CALC cycles, at least 1.
  - MODE 0 worst case ~2^WIDTH cycles.
  - MODE 1 bounded by ~4*WIDTH cycles.
- Boundary cases:
  - gcd(0,0)=0, gcd(x,0)=x, gcd(0,y)=y, gcd(x,x)=x in both modes.
  - operands_valid while ready=0: ignored, no queuing.
  - ack outside DONE: ignored.
  - ack held high continuously: DONE lasts exactly 1 cycle.
  - operands_valid in the cycle after leaving DONE: accepted normally.

Optional Feature:
- Macro: GCD_CYCLE_COUNT_EN.
- Defined:
  - Adds output port cycles [CNT_W-1:0].
  - Counts CALC cycles of the current operation and saturates at all-ones.
  - Valid while gcd_valid=1; holds until the next capture; reset value 0.
- Undefined:
  - Port and counter are absent.
  - Function and latency are otherwise identical.

Test Plan:
- MODE0, A=32, B=16, ack 5 cycles after gcd_valid -> gcd_out=16; gcd_valid 4 cycles after accept, held until ack; cycles=4.
- MODE1, A=32, B=16 -> gcd_out=16 after 7 CALC cycles (cycles=7); MODE1, A=48, B=18 -> 6; MODE0, A=48, B=18 -> 6.
- Zero operands, both modes: (0,0)->0 in 1 cycle; (0,9)->9; (9,0)->9.
- Reset mid-operation: MODE0, A=65535, B=1; pulse reset_n low after 100 cycles -> immediately ready=1, gcd_valid=0, gcd_out=0; next operands (12,8) -> 4.
- Handshake: operands_valid pulsed during CALC -> ignored, result unchanged; ack held high -> gcd_valid high for exactly 1 cycle, ready=1 the cycle after.
- WIDTH=32, MODE1, A=0xFFFFFFFF, B=0xFFFF0000 -> gcd_out=0x0000FFFF; compare every case against a behavioural GCD model.
